// File: rtl/snake_engine_pkg.sv
// Shared types and constants for the snake body engine: FSM encoding and key codes.
// The helper function detects a head-on reversal request.
package snake_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_READY  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_COMMIT = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  localparam logic [1:0] KEY_W        = 2'b00;
  localparam logic [1:0] KEY_A        = 2'b01;
  localparam logic [1:0] KEY_S        = 2'b11;
  localparam logic [1:0] KEY_D        = 2'b10;
  localparam logic [1:0] REVERSE_MASK = 2'b11;

  // Opposite directions differ in both key bits (w/s and a/d).
  function automatic logic key_reverses(input logic [1:0] cur, input logic [1:0] req);
    return (cur ^ req) == REVERSE_MASK;
  endfunction

endpackage

// File: rtl/snake_engine_if.sv
// Control/readout bundle between the game logic (master) and the snake engine (slave).
// start/step/grow/key are one-cycle requests; step is taken only in READY, done pulses once per finished init or move.
interface snake_engine_if #(
  parameter int COORD_W = 8
);
  logic               start;
  logic               step;
  logic               grow;
  logic [1:0]         key;
  logic [15:0]        rd_idx;
  logic [15:0]        length;
  logic [1:0]         true_key;
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic               busy;
  logic               done;
  logic               game_over;
  logic               full;

  modport master (
    output start, step, grow, key, rd_idx,
    input  length, true_key, head_x, head_y, rd_x, rd_y, busy, done, game_over, full
  );

  modport slave (
    input  start, step, grow, key, rd_idx,
    output length, true_key, head_x, head_y, rd_x, rd_y, busy, done, game_over, full
  );
endinterface

// File: rtl/snake_engine_ring_ram.sv
// Body storage: one write port, a combinational compare read port and a registered readout port.
// The readout port returns zero when the requested segment does not exist.
module snake_engine_ring_ram #(
  parameter int DEPTH = 100,
  parameter int AW    = 7,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] cmp_addr,
  output logic [DW-1:0] cmp_data,
  input  logic          rd_valid,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Contents are meaningless until INIT rewrites them, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign cmp_data = mem[cmp_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_valid ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Snake body engine: FSM, ring pointers, length counter and next-head arithmetic.
// The body lives head-relative in a circular buffer; segment k sits at (head_ptr + k) mod MAX_LEN.
module snake_engine
  import snake_engine_pkg::*;
#(
  parameter int SIZE_X   = 10,
  parameter int SIZE_Y   = 10,
  parameter int COORD_W  = 8,
  parameter int MAX_LEN  = SIZE_X * SIZE_Y,
  parameter int INIT_LEN = 4,
  parameter int WRAP     = 0
) (
  input  logic           clk,
  input  logic           rst,
  snake_engine_if.slave  bus,
  output state_t         state_dbg
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DW = 2 * COORD_W;
  localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(SIZE_X - 1);
  localparam logic [COORD_W-1:0] Y_MAX      = COORD_W'(SIZE_Y - 1);
  localparam logic [COORD_W-1:0] Y_MID      = COORD_W'(SIZE_Y / 2);
  localparam logic [COORD_W-1:0] INIT_HEADX = COORD_W'(INIT_LEN - 1);
  localparam logic [15:0]        INIT_LEN_W = 16'(INIT_LEN);
  localparam logic [15:0]        MAX_LEN_W  = 16'(MAX_LEN);
  localparam logic [AW-1:0]      LAST_ADDR  = AW'(MAX_LEN - 1);

  function automatic logic [AW-1:0] ring_add(input logic [AW-1:0] base, input logic [15:0] off);
    logic [16:0] sum;
    sum = 17'(base) + 17'(off);
    if (sum >= 17'(MAX_LEN)) begin
      sum = sum - 17'(MAX_LEN);
    end
    return sum[AW-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [AW-1:0]      head_ptr_q;
  logic [15:0]        length_q;
  logic [15:0]        init_idx_q;
  logic [15:0]        cmp_idx_q;
  logic [15:0]        cmp_cnt_q;
  logic [1:0]         true_key_q;
  logic [COORD_W-1:0] head_x_q, head_y_q;
  logic [COORD_W-1:0] nxt_x_q, nxt_y_q;
  logic               oob_q, grow_q;
  logic               done_q, game_over_q, full_q;

  logic [1:0]         eff_key;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic               cand_oob;
  logic [15:0]        cmp_cnt_d;
  logic [AW-1:0]      head_dec;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [DW-1:0]      cmp_data;
  logic [DW-1:0]      rd_data;
  logic               hit;
  logic               last_cmp;
  logic               init_last;

  assign eff_key   = key_reverses(true_key_q, bus.key) ? true_key_q : bus.key;
  assign cmp_cnt_d = bus.grow ? length_q : length_q - 16'd1;
  assign head_dec  = (head_ptr_q == '0) ? LAST_ADDR : head_ptr_q - AW'(1);
  assign hit       = (cmp_data == {nxt_x_q, nxt_y_q});
  assign last_cmp  = (cmp_idx_q == cmp_cnt_q - 16'd1);
  assign init_last = (init_idx_q == INIT_LEN_W - 16'd1);

  // Candidate head from the direction that will be in effect after this step.
  always_comb begin
    cand_x   = head_x_q;
    cand_y   = head_y_q;
    cand_oob = 1'b0;
    unique case (eff_key)
      KEY_D: begin
        if (head_x_q == X_MAX) begin
          if (WRAP != 0) cand_x = '0;
          else           cand_oob = 1'b1;
        end else begin
          cand_x = head_x_q + COORD_W'(1);
        end
      end
      KEY_A: begin
        if (head_x_q == '0) begin
          if (WRAP != 0) cand_x = X_MAX;
          else           cand_oob = 1'b1;
        end else begin
          cand_x = head_x_q - COORD_W'(1);
        end
      end
      KEY_W: begin
        if (head_y_q == Y_MAX) begin
          if (WRAP != 0) cand_y = '0;
          else           cand_oob = 1'b1;
        end else begin
          cand_y = head_y_q + COORD_W'(1);
        end
      end
      KEY_S: begin
        if (head_y_q == '0) begin
          if (WRAP != 0) cand_y = Y_MAX;
          else           cand_oob = 1'b1;
        end else begin
          cand_y = head_y_q - COORD_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An out-of-range move still spends one CHECK cycle so a wall hit shows busy before done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   state_d = ST_IDLE;
      ST_INIT:   if (init_last) state_d = ST_READY;
      ST_READY: begin
        if (bus.step) begin
          state_d = (cand_oob || (cmp_cnt_d != 16'd0)) ? ST_CHECK : ST_COMMIT;
        end
      end
      ST_CHECK: begin
        if (oob_q || hit) state_d = ST_OVER;
        else if (last_cmp) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_READY;
      ST_OVER:   state_d = ST_OVER;
      default:   state_d = ST_IDLE;
    endcase
    if (bus.start) begin
      state_d = (INIT_LEN > 1) ? ST_INIT : ST_READY;
    end
  end

  // Segment 0 is written on the start edge, the remaining INIT_LEN-1 during INIT.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (bus.start) begin
      wr_en   = 1'b1;
      wr_data = {INIT_HEADX, Y_MID};
    end else if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = init_idx_q[AW-1:0];
      wr_data = {COORD_W'(32'(INIT_LEN - 1) - 32'(init_idx_q)), Y_MID};
    end else if (state_q == ST_COMMIT) begin
      wr_en   = 1'b1;
      wr_addr = head_dec;
      wr_data = {nxt_x_q, nxt_y_q};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr_q  <= '0;
      length_q    <= '0;
      init_idx_q  <= '0;
      cmp_idx_q   <= '0;
      cmp_cnt_q   <= '0;
      true_key_q  <= KEY_D;
      head_x_q    <= '0;
      head_y_q    <= '0;
      nxt_x_q     <= '0;
      nxt_y_q     <= '0;
      oob_q       <= 1'b0;
      grow_q      <= 1'b0;
      done_q      <= 1'b0;
      game_over_q <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        head_ptr_q  <= '0;
        length_q    <= INIT_LEN_W;
        init_idx_q  <= 16'd1;
        true_key_q  <= KEY_D;
        head_x_q    <= INIT_HEADX;
        head_y_q    <= Y_MID;
        game_over_q <= 1'b0;
        full_q      <= 1'b0;
        done_q      <= (INIT_LEN == 1);
      end else begin
        unique case (state_q)
          ST_INIT: begin
            init_idx_q <= init_idx_q + 16'd1;
            if (init_last) done_q <= 1'b1;
          end
          ST_READY: begin
            if (bus.step) begin
              true_key_q <= eff_key;
              nxt_x_q    <= cand_x;
              nxt_y_q    <= cand_y;
              oob_q      <= cand_oob;
              grow_q     <= bus.grow;
              cmp_cnt_q  <= cmp_cnt_d;
              cmp_idx_q  <= '0;
            end
          end
          ST_CHECK: begin
            if (oob_q || hit) begin
              game_over_q <= 1'b1;
              done_q      <= 1'b1;
            end else begin
              cmp_idx_q <= cmp_idx_q + 16'd1;
            end
          end
          ST_COMMIT: begin
            head_ptr_q <= head_dec;
            head_x_q   <= nxt_x_q;
            head_y_q   <= nxt_y_q;
            done_q     <= 1'b1;
            // Growing past capacity flags full and behaves like a plain move.
            if (grow_q) begin
              if (length_q < MAX_LEN_W) length_q <= length_q + 16'd1;
              else                      full_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  snake_engine_ring_ram #(
    .DEPTH (MAX_LEN),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cmp_addr (ring_add(head_ptr_q, cmp_idx_q)),
    .cmp_data (cmp_data),
    .rd_valid (bus.rd_idx < length_q),
    .rd_addr  (ring_add(head_ptr_q, bus.rd_idx)),
    .rd_data  (rd_data)
  );

  assign bus.length    = length_q;
  assign bus.true_key  = true_key_q;
  assign bus.head_x    = head_x_q;
  assign bus.head_y    = head_y_q;
  assign bus.rd_x      = rd_data[DW-1:COORD_W];
  assign bus.rd_y      = rd_data[COORD_W-1:0];
  assign bus.busy      = (state_q == ST_CHECK) || (state_q == ST_COMMIT);
  assign bus.done      = done_q;
  assign bus.game_over = game_over_q;
  assign bus.full      = full_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: a wall-mode instance (defaults) and a wrap-mode instance with MAX_LEN=4.
// Expected values are hand-derived from the game rules.
module tb_snake_engine;
  import snake_engine_pkg::*;

  logic   clk;
  logic   rst0, rst1;
  state_t st0, st1;
  int     checks;
  int     failures;
  int     lat;
  logic   b1;
  logic [7:0] rx, ry;

  snake_engine_if #(.COORD_W(8)) if0 ();
  snake_engine_if #(.COORD_W(8)) if1 ();

  snake_engine #(.WRAP(0)) dut0 (
    .clk       (clk),
    .rst       (rst0),
    .bus       (if0),
    .state_dbg (st0)
  );

  snake_engine #(.WRAP(1), .MAX_LEN(4)) dut1 (
    .clk       (clk),
    .rst       (rst1),
    .bus       (if1),
    .state_dbg (st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s_start, input logic s_step,
                       input logic s_grow, input logic [1:0] s_key);
    if (sel == 0) begin
      if0.start = s_start; if0.step = s_step; if0.grow = s_grow; if0.key = s_key;
    end else begin
      if1.start = s_start; if1.step = s_step; if1.grow = s_grow; if1.key = s_key;
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? if0.done : if1.done;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? if0.busy : if1.busy;
  endfunction

  // One-cycle request, then count cycles until done (20 means it never came).
  task automatic pulse(input int sel, input logic s_start, input logic s_step, input logic s_grow,
                       input logic [1:0] s_key, output int n, output logic busy1);
    @(negedge clk);
    drive(sel, s_start, s_step, s_grow, s_key);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 1'b0, s_key);
    n = 1;
    busy1 = get_busy(sel);
    while (!get_done(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic read_seg(input int sel, input int idx, output logic [7:0] x, output logic [7:0] y);
    @(negedge clk);
    if (sel == 0) if0.rd_idx = 16'(idx);
    else          if1.rd_idx = 16'(idx);
    @(negedge clk);
    x = (sel == 0) ? if0.rd_x : if1.rd_x;
    y = (sel == 0) ? if0.rd_y : if1.rd_y;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst0 = 1'b0;
    rst1 = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, KEY_D);
    drive(1, 1'b0, 1'b0, 1'b0, KEY_D);
    if0.rd_idx = '0;
    if1.rd_idx = '0;
    #12;

    // Reset state
    check("rst_length",   32'(if0.length), 32'd0);
    check("rst_true_key", 32'(if0.true_key), 32'd2);
    check("rst_head",     {16'd0, if0.head_x, if0.head_y}, 32'd0);
    check("rst_flags",    {28'd0, if0.busy, if0.done, if0.game_over, if0.full}, 32'd0);
    check("rst_rd",       {16'd0, if0.rd_x, if0.rd_y}, 32'd0);
    check("rst_state",    32'(st0), 32'(ST_IDLE));
    @(negedge clk);
    rst0 = 1'b1;
    rst1 = 1'b1;

    // Start: done 4 cycles later, straight body along y=5
    pulse(0, 1'b1, 1'b0, 1'b0, KEY_D, lat, b1);
    check("init_latency", 32'(lat), 32'd4);
    check("init_length",  32'(if0.length), 32'd4);
    check("init_head",    {16'd0, if0.head_x, if0.head_y}, {16'd0, 8'd3, 8'd5});
    check("init_state",   32'(st0), 32'(ST_READY));
    @(negedge clk);
    check("done_one_cycle", 32'(if0.done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      read_seg(0, k, rx, ry);
      check($sformatf("init_seg%0d", k), {16'd0, rx, ry}, {16'd0, 8'(3 - k), 8'd5});
    end
    read_seg(0, 4, rx, ry);
    check("rd_beyond_len", {16'd0, rx, ry}, 32'd0);

    // Step right: 3 compares -> done 5 cycles after step
    pulse(0, 1'b0, 1'b1, 1'b0, KEY_D, lat, b1);
    check("step_busy", 32'(b1), 32'd1);
    check("step_latency", 32'(lat), 32'd5);
    check("step_head", {16'd0, if0.head_x, if0.head_y}, {16'd0, 8'd4, 8'd5});
    check("step_busy_after", 32'(if0.busy), 32'd0);
    read_seg(0, 3, rx, ry);
    check("step_tail", {16'd0, rx, ry}, {16'd0, 8'd1, 8'd5});

    // Reversal (a while heading d) is ignored
    pulse(0, 1'b0, 1'b1, 1'b0, KEY_A, lat, b1);
    check("rev_head", {16'd0, if0.head_x, if0.head_y}, {16'd0, 8'd5, 8'd5});
    check("rev_true_key", 32'(if0.true_key), 32'(KEY_D));

    // Grow to 5 (4 compares), then s, a, w runs into its own body
    pulse(0, 1'b0, 1'b1, 1'b1, KEY_D, lat, b1);
    check("grow_latency", 32'(lat), 32'd6);
    check("grow_length",  32'(if0.length), 32'd5);
    check("grow_head",    {16'd0, if0.head_x, if0.head_y}, {16'd0, 8'd6, 8'd5});
    pulse(0, 1'b0, 1'b1, 1'b0, KEY_S, lat, b1);
    check("s_head", {16'd0, if0.head_x, if0.head_y}, {16'd0, 8'd6, 8'd4});
    check("s_true_key", 32'(if0.true_key), 32'(KEY_S));
    pulse(0, 1'b0, 1'b1, 1'b0, KEY_A, lat, b1);
    check("a_head", {16'd0, if0.head_x, if0.head_y}, {16'd0, 8'd5, 8'd4});
    pulse(0, 1'b0, 1'b1, 1'b0, KEY_W, lat, b1);
    check("self_latency", 32'(lat), 32'd5);
    check("self_over",    32'(if0.game_over), 32'd1);
    check("self_length",  32'(if0.length), 32'd5);
    check("self_head",    {16'd0, if0.head_x, if0.head_y}, {16'd0, 8'd5, 8'd4});

    // Steps are ignored in OVER
    pulse(0, 1'b0, 1'b1, 1'b0, KEY_A, lat, b1);
    check("over_no_done", 32'(lat), 32'd20);
    check("over_head",    {16'd0, if0.head_x, if0.head_y}, {16'd0, 8'd5, 8'd4});
    check("over_state",   32'(st0), 32'(ST_OVER));

    // Restart and run into the right wall
    pulse(0, 1'b1, 1'b0, 1'b0, KEY_D, lat, b1);
    check("restart_over",   32'(if0.game_over), 32'd0);
    check("restart_length", 32'(if0.length), 32'd4);
    for (int k = 0; k < 6; k++) begin
      pulse(0, 1'b0, 1'b1, 1'b0, KEY_D, lat, b1);
    end
    check("edge_head", {16'd0, if0.head_x, if0.head_y}, {16'd0, 8'd9, 8'd5});
    pulse(0, 1'b0, 1'b1, 1'b0, KEY_D, lat, b1);
    check("wall_latency", 32'(lat), 32'd2);
    check("wall_over",    32'(if0.game_over), 32'd1);
    check("wall_head",    {16'd0, if0.head_x, if0.head_y}, {16'd0, 8'd9, 8'd5});
    read_seg(0, 0, rx, ry);
    check("wall_seg0", {16'd0, rx, ry}, {16'd0, 8'd9, 8'd5});
    read_seg(0, 3, rx, ry);
    check("wall_seg3", {16'd0, rx, ry}, {16'd0, 8'd6, 8'd5});

    // Wrap instance: same move wraps to x=0; then grow at MAX_LEN sets full
    pulse(1, 1'b1, 1'b0, 1'b0, KEY_D, lat, b1);
    check("w_init_latency", 32'(lat), 32'd4);
    for (int k = 0; k < 6; k++) begin
      pulse(1, 1'b0, 1'b1, 1'b0, KEY_D, lat, b1);
    end
    pulse(1, 1'b0, 1'b1, 1'b0, KEY_D, lat, b1);
    check("wrap_latency", 32'(lat), 32'd5);
    check("wrap_head",    {16'd0, if1.head_x, if1.head_y}, {16'd0, 8'd0, 8'd5});
    check("wrap_over",    32'(if1.game_over), 32'd0);
    pulse(1, 1'b0, 1'b1, 1'b1, KEY_D, lat, b1);
    check("full_latency", 32'(lat), 32'd6);
    check("full_flag",    32'(if1.full), 32'd1);
    check("full_length",  32'(if1.length), 32'd4);
    check("full_head",    {16'd0, if1.head_x, if1.head_y}, {16'd0, 8'd1, 8'd5});
    read_seg(1, 3, rx, ry);
    check("full_tail", {16'd0, rx, ry}, {16'd0, 8'd8, 8'd5});

    // Reset in the middle of CHECK
    pulse(0, 1'b1, 1'b0, 1'b0, KEY_D, lat, b1);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0, KEY_W);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, KEY_W);
    check("mid_state", 32'(st0), 32'(ST_CHECK));
    rst0 = 1'b0;
    #1;
    check("arst_state",    32'(st0), 32'(ST_IDLE));
    check("arst_length",   32'(if0.length), 32'd0);
    check("arst_head",     {16'd0, if0.head_x, if0.head_y}, 32'd0);
    check("arst_flags",    {28'd0, if0.busy, if0.done, if0.game_over, if0.full}, 32'd0);
    check("arst_true_key", 32'(if0.true_key), 32'd2);
    check("arst_rd",       {16'd0, if0.rd_x, if0.rd_y}, 32'd0);
    @(negedge clk);
    rst0 = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_state", 32'(st0), 32'(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
